// File: rtl/TicSAT_pkg.sv
// TicSAT_pkg: types shared by the TicSAT systolic-array blocks.
//   command_t : array command broadcast to the datapath each cycle. Only
//               CMD_STREAM moves data through the array and its skew buffers.
package TicSAT_pkg;

  typedef enum logic [1:0] {
    CMD_QUEUE  = 2'd0,
    CMD_STREAM = 2'd1,
    CMD_IDLE   = 2'd2,
    CMD_FLUSH  = 2'd3
  } command_t;

endpackage

// File: rtl/fifo_out_deskew_row_fifo.sv
// row_fifo: small FIFO of whole result rows with the head row visible
// combinationally, so a pushed row can be drained the cycle after its push.
//   clk, resetn : clock, asynchronous active-low reset
//   push        : write push_data (ignored when full unless pop is also set)
//   push_data   : row to write, WIDTH bits
//   pop         : remove the head row (ignored when empty)
//   head_data   : current head row (undefined while empty)
//   full, empty : occupancy flags
//   count       : rows held, 0..DEPTH
module row_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // When full, a push is still taken if the head leaves on the same edge:
  // wr_ptr equals rd_ptr then, so the new row lands in the slot being freed.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Storage has no reset; the occupancy logic decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr_reg];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fifo_out_deskew.sv
// fifo_out_deskew: realigns skewed accumulator results leaving the bottom of
// the systolic array, buffers whole rows, and drains them one element per
// valid/ready handshake in column order.
//   clk, resetn  : clock, asynchronous active-low reset
//   cmd          : array command; deskew stages shift only on CMD_STREAM
//   in_data      : per-column result at the array bottom (column c lags c cycles)
//   in_valid     : column-0 element of a result row present this cycle
//   out_data     : element being drained (0 while out_valid is low)
//   out_col_idx  : column of out_data
//   out_last     : out_data is the final column of its row
//   out_valid    : an element is available
//   out_ready    : host accepts the element
//   overflow     : sticky, an aligned row was dropped because the FIFO was full
//   rows_avail   : rows held in the row FIFO
module fifo_out_deskew
  import TicSAT_pkg::*;
#(
  parameter int SA_SIZE   = 8,
  parameter int ACC_SIZE  = 32,
  parameter int ROW_DEPTH = 4
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  command_t                                      cmd,
  input  logic [ACC_SIZE-1:0]                           in_data [SA_SIZE-1:0],
  input  logic                                          in_valid,
  output logic [ACC_SIZE-1:0]                           out_data,
  output logic [((SA_SIZE > 1) ? $clog2(SA_SIZE) : 1)-1:0] out_col_idx,
  output logic                                          out_last,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic                                          overflow,
  output logic [$clog2(ROW_DEPTH):0]                    rows_avail
);

  localparam int CW = (SA_SIZE > 1) ? $clog2(SA_SIZE) : 1;
  localparam int RW = ACC_SIZE * SA_SIZE;

  logic                stream;
  logic [ACC_SIZE-1:0] aligned  [SA_SIZE];
  logic [ACC_SIZE-1:0] out_cols [SA_SIZE];
  logic [RW-1:0]       aligned_row;
  logic [RW-1:0]       head_row;
  logic                aligned_valid;
  logic                push;
  logic                pop;
  logic                handshake;
  logic                last_col;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       col_cnt_reg;
  logic                overflow_reg;

  assign stream = (cmd == CMD_STREAM);

  // Deskew: column gi gets SA_SIZE-1-gi delay stages so every column of a
  // row emerges on the stream cycle its last column arrives. The last column
  // needs no delay and is taken straight from in_data at push time.
  genvar gi;
  generate
    for (gi = 0; gi < SA_SIZE; gi++) begin : g_col
      localparam int DLY = SA_SIZE - 1 - gi;
      if (DLY == 0) begin : g_pass
        assign aligned[gi] = in_data[gi];
      end else begin : g_dly
        logic [ACC_SIZE-1:0] stage [DLY];
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) begin
            for (int k = 0; k < DLY; k++) stage[k] <= '0;
          end else if (stream) begin
            stage[0] <= in_data[gi];
            for (int k = 1; k < DLY; k++) stage[k] <= stage[k-1];
          end
        end
        assign aligned[gi] = stage[DLY-1];
      end
      assign aligned_row[gi*ACC_SIZE +: ACC_SIZE] = aligned[gi];
      assign out_cols[gi] = head_row[gi*ACC_SIZE +: ACC_SIZE];
    end

    // Valid tag travels with column 0 so it marks the cycle the row is aligned.
    if (SA_SIZE == 1) begin : g_tag_none
      assign aligned_valid = in_valid;
    end else begin : g_tag
      logic [SA_SIZE-2:0] tag;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          tag <= '0;
        end else if (stream) begin
          tag[0] <= in_valid;
          for (int k = 1; k < SA_SIZE - 1; k++) tag[k] <= tag[k-1];
        end
      end
      assign aligned_valid = tag[SA_SIZE-2];
    end
  endgenerate

  assign push      = aligned_valid && stream;
  assign out_valid = !fifo_empty;
  assign last_col  = (col_cnt_reg == CW'(SA_SIZE - 1));
  assign handshake = out_valid && out_ready;
  assign pop       = handshake && last_col;

  row_fifo #(
    .WIDTH (RW),
    .DEPTH (ROW_DEPTH)
  ) u_row_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (aligned_row),
    .pop       (pop),
    .head_data (head_row),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rows_avail)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_cnt_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (handshake) begin
        col_cnt_reg <= last_col ? '0 : col_cnt_reg + CW'(1);
      end
      // Matches the FIFO's drop condition: full with no departing row.
      if (push && fifo_full && !pop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // Gate data with out_valid so stale or never-written storage is not shown.
  assign out_data    = out_valid ? out_cols[col_cnt_reg] : '0;
  assign out_col_idx = col_cnt_reg;
  assign out_last    = out_valid && last_col;
  assign overflow    = overflow_reg;

endmodule

// File: doc/fifo_out_deskew.md
Name: fifo_out_deskew

Overview:
- Output-side counterpart of the activation input skew buffer.
- Collects accumulator results leaving the bottom of the systolic array. These arrive skewed: column c lags column 0 by c stream cycles.
- Realigns each result row, buffers whole rows in a small row FIFO, and drains them to the host one element per valid/ready handshake, in column order.

Parameters:
- SA_SIZE, 8, array dimension (columns per result row); >=1
- ACC_SIZE, 32, width of one accumulator result
- ROW_DEPTH, 4, aligned rows buffered; power of 2, >=2

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- cmd  input  command_t  array command; shifting only on CMD_STREAM
- in_data  input  ACC_SIZE x SA_SIZE (unpacked [SA_SIZE-1:0])  per-column result at array bottom
- in_valid  input  1  column-0 element of a result row present this cycle
- out_data  output  ACC_SIZE  result element being drained
- out_col_idx  output  $clog2(SA_SIZE) (min 1)  column of out_data
- out_last  output  1  out_data is the final column of its row
- out_valid  output  1  out_data valid
- out_ready  input  1  host accepts element
- overflow  output  1  sticky: an aligned row was dropped
- rows_avail  output  $clog2(ROW_DEPTH)+1  rows held in FIFO

Behaviour:
- Deskew: column c has D_c = SA_SIZE-1-c registers.
  - Column SA_SIZE-1 passes combinationally.
  - All stages shift only in cycles with cmd==CMD_STREAM; otherwise they hold.
  - A valid tag pipeline of SA_SIZE-1 registers carries in_valid under the same enable.
  - aligned_valid = last tag stage output (in_valid when SA_SIZE==1).
- Timing contract: a row's column-c element is presented on the c-th stream cycle after its column-0 element. Non-stream cycles in between are allowed (stall).
- Push: push = aligned_valid && cmd==CMD_STREAM. The aligned row is written at that clock edge.
- Latency: if the column-0 element is sampled on stream cycle t, the push occurs at the end of stream cycle t+SA_SIZE-1. out_valid rises the following cycle if the FIFO was empty.
- Drain:
  - out_valid = FIFO not empty.
  - out_data = head row[col_cnt]; out_col_idx = col_cnt.
  - out_last = (col_cnt==SA_SIZE-1).
  - Handshake occurs when out_valid && out_ready. col_cnt increments; on out_last it wraps to 0 and the head row is popped.
  - out_data and out_col_idx are stable while out_valid && !out_ready.
- Full and simultaneous events:
  - Full and push without a pop in the same cycle: row dropped, overflow set to 1 on that edge.
  - Full and push coinciding with a popping handshake (last column): push accepted, no overflow, rows_avail unchanged.
  - Push into an empty FIFO: visible at out_valid one cycle later (no fall-through).
- Pointers: read and write pointers wrap modulo ROW_DEPTH. rows_avail ranges 0..ROW_DEPTH.
- overflow clears only on reset.
- Reset (async assert, any time, including mid-drain):
  - Deskew data and tags clear to 0.
  - FIFO empty; col_cnt 0.
  - out_valid 0, out_last 0, out_col_idx 0, out_data 0, overflow 0, rows_avail 0.
  - Partially drained and partially skewed rows are discarded.
- in_data is ignored except when sampled into the deskew stages during CMD_STREAM cycles. In particular, column SA_SIZE-1 is only observed on push.

Decomposition:
- command_t (CMD_QUEUE, CMD_STREAM, ...) stays in the shared TicSAT_pkg. No new package types are needed.
- One sub-module, row_fifo:
  - parameterised by width and depth;
  - ports: push, push data, pop, head data, full, empty, count;
  - asynchronous active-low reset;
  - push-when-full-with-pop supported.
- Deskew stages and drain counter live in the top.

Test Plan (SA_SIZE=4, ACC_SIZE=32, ROW_DEPTH=2):
- Reset: assert resetn=0 mid-operation -> all outputs 0 immediately, with no clock edge needed; after release, out_valid stays 0 with no input.
- Single row, out_ready=1, cmd=CMD_STREAM for 4 cycles:
  - stimulus: cycle0 in_valid=1, col0=0x10; cycle1 col1=0x11; cycle2 col2=0x12; cycle3 col3=0x13.
  - response: out_valid from cycle4; data 0x10..0x13 on cycles 4..7; out_col_idx 0..3; out_last only at cycle7.
- Stall: same row, but with a non-stream cmd inserted between cycle1 and cycle2 for 3 cycles -> the same 4 values are drained, first out_valid 3 cycles later.
- Backpressure: out_ready=0 while streaming rows A, B, C back-to-back -> rows_avail=2, overflow=1 after C is dropped; then out_ready=1 -> only A then B drained, 8 elements.
- Full and pop: FIFO holds A, B; row C's push lands in the same cycle as B... A's last-column handshake -> no overflow; B then C are drained.
- Reset mid-drain: resetn pulse after column 1 of a row is accepted -> out_valid=0, rows_avail=0; the next streamed row drains from out_col_idx 0.
